// File: rtl/coord_loader.sv
// coord_loader
// Assembles DIMS coordinate components, received one beat at a time over a
// valid/ready handshake, into a packed coordinate word. It writes each
// finished word to node memory at the next sequential address and then waits
// for a next-coordinate or finish command.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   coord_valid     component beat valid
//   coord_data      component value, component 0 (x) first
//   coord_ready     beat accepted when coord_valid && coord_ready
//   next_coord      single-cycle command: collect another coordinate
//   finish          single-cycle command: end initialisation
//   restart         synchronous clear back to empty/COLLECT
//   mem_we          node memory write strobe
//   mem_addr        node memory write address
//   mem_wdata       packed coordinate, component k at [k*COORD_W +: COORD_W]
//   count           coordinates written (0..DEPTH)
//   full            count == DEPTH
//   done            initialisation finished
//   err_overflow    sticky: next_coord while full
//   err_partial     sticky: finish while a coordinate was partially collected
//
// States:
//   COLLECT  | accepting component beats into the assembly register
//   WRITE    | one-cycle memory write of the assembled coordinate
//   WAIT_CMD | waiting for next_coord or finish
//   FINISH   | initialisation complete; held until restart or reset
module coord_loader #(
  parameter int COORD_W = 8,
  parameter int DIMS    = 2,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      coord_valid,
  input  logic [COORD_W-1:0]        coord_data,
  output logic                      coord_ready,
  input  logic                      next_coord,
  input  logic                      finish,
  input  logic                      restart,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DIMS*COORD_W-1:0]   mem_wdata,
  output logic [ADDR_W:0]           count,
  output logic                      full,
  output logic                      done,
  output logic                      err_overflow,
  output logic                      err_partial
);

  localparam int DIM_W = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam logic [DIM_W-1:0]  LAST_DIM  = DIM_W'(DIMS - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    WRITE    = 2'd1,
    WAIT_CMD = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t                  state;
  logic [DIM_W-1:0]        dim_idx;
  logic [DIMS*COORD_W-1:0] assembly;

  // Outputs decode only from registered state, so no input reaches an output
  // combinationally.
  assign coord_ready = (state == COLLECT);
  assign mem_we      = (state == WRITE);
  assign done        = (state == FINISH);
  assign mem_addr    = count[ADDR_W-1:0];
  assign mem_wdata   = assembly;
  assign full        = (count == DEPTH_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= COLLECT;
      dim_idx      <= '0;
      assembly     <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
      err_partial  <= 1'b0;
    end else if (restart) begin
      state        <= COLLECT;
      dim_idx      <= '0;
      assembly     <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
      err_partial  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          // finish wins over a coincident beat; any partial coordinate is dropped.
          if (finish) begin
            if (dim_idx != '0) err_partial <= 1'b1;
            dim_idx <= '0;
            state   <= FINISH;
          end else if (coord_valid) begin
            for (int k = 0; k < DIMS; k++) begin
              if (dim_idx == DIM_W'(k)) assembly[k*COORD_W +: COORD_W] <= coord_data;
            end
            if (dim_idx == LAST_DIM) begin
              dim_idx <= '0;
              state   <= WRITE;
            end else begin
              dim_idx <= dim_idx + 1'b1;
            end
          end
        end
        WRITE: begin
          if (count != DEPTH_CNT) count <= count + 1'b1;
          state <= WAIT_CMD;
        end
        WAIT_CMD: begin
          if (finish) begin
            state <= FINISH;
          end else if (next_coord) begin
            if (full) err_overflow <= 1'b1;
            else      state        <= COLLECT;
          end
        end
        FINISH: state <= FINISH;
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/coord_loader.md
# coord_loader

Parametrised coordinate-ingest block for the pathfinding accelerator's initialisation phase. It accepts coordinate components one beat at a time over a valid/ready handshake and assembles DIMS components into one packed coordinate word. Each completed coordinate is written to the node memory at a sequential address, and the block then waits for a next-coordinate or finish command. It reports fill count, full, done, and sticky error flags to the init controller.

## Interface
- COORD_W, 8, width of one coordinate component
- DIMS, 2, components per coordinate (x, y[, z...]); ≥1
- DEPTH, 64, node memory entries; power of two ≥2
- ADDR_W, $clog2(DEPTH), memory address width (derived)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- coord_valid  in  1  component beat valid
- coord_data  in  COORD_W  component value; component 0 (x) first
- coord_ready  out  1  beat accepted when coord_valid && coord_ready
- next_coord  in  1  single-cycle command: collect another coordinate
- finish  in  1  single-cycle command: end initialisation
- restart  in  1  synchronous clear back to empty/COLLECT
- mem_we  out  1  node memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DIMS*COORD_W  packed coordinate; component k at bits [k*COORD_W +: COORD_W]
- count  out  ADDR_W+1  coordinates written (0..DEPTH)
- full  out  1  count == DEPTH
- done  out  1  FINISH state
- err_overflow  out  1  sticky: next_coord while full
- err_partial  out  1  sticky: finish while a coordinate was partially collected

## Operation
- States: COLLECT, WRITE, WAIT_CMD, FINISH. Reset state COLLECT.
- COLLECT: coord_ready=1. Each accepted beat stores coord_data into lane dim_idx of the assembly register, then increments dim_idx. On the beat with dim_idx==DIMS-1, dim_idx returns to 0 and the state moves to WRITE.
- WRITE (one cycle): mem_we=1, mem_addr=count[ADDR_W-1:0], mem_wdata=assembly register; count increments at end of cycle; go WAIT_CMD.
- WAIT_CMD: coord_ready=0.
  - finish → FINISH; it has priority over next_coord.
  - next_coord with !full → COLLECT.
  - next_coord with full → stay in WAIT_CMD and set err_overflow.
  - Otherwise hold.
- FINISH: done=1, coord_ready=0. Commands and beats are ignored. Held until restart or reset.
- finish in COLLECT:
  - dim_idx==0 → FINISH, no error.
  - dim_idx≠0 → discard the partial coordinate, set err_partial, go FINISH.
- next_coord in COLLECT or WRITE is ignored.
- restart (any state, priority over all other inputs): next cycle state=COLLECT; count, dim_idx, assembly, done, and both err flags are cleared.
- count saturates at DEPTH. WRITE is only reachable with !full, so no address wrap ever occurs.

## Timing
- Reset values: coord_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, done=0, err_overflow=0, err_partial=0.
- Last component accepted at cycle t → mem_we=1 at t+1 → count/full updated at t+2.
- DIMS=2 minimum coordinate throughput: 2 beats + WRITE + 1 WAIT_CMD cycle (next_coord sampled) = 4 cycles.
- finish sampled at t → done=1 at t+1.
- Error flags set the cycle after the triggering command.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Reset asserted mid-coordinate: the partial coordinate is lost, with no write and no error.

## Test plan
(DIMS=2, COORD_W=8, DEPTH=4)
- Beats 0x12, 0x34 with continuous valid → one write: mem_addr=0, mem_wdata=0x3412; count=1 two cycles after the second beat.
- Four coordinates with next_coord between them, then next_coord → writes at addresses 0..3, full=1, err_overflow=1, no fifth mem_we, state stays WAIT_CMD.
- One coordinate, then finish and next_coord asserted in the same cycle → done=1 next cycle; further beats see coord_ready=0.
- Beat 0x55 only, then finish → err_partial=1, done=1, no mem_we, count=0.
- Valid gaps, with coord_valid toggling every other cycle over beats 0xAA, 0xBB → a single write, mem_wdata=0xBBAA.
- restart asserted in FINISH with both errors set → the next cycle shows COLLECT, count=0, all flags 0, and the next coordinate is written at address 0. Also assert async reset mid-beat → all outputs return to reset values immediately.
